boot_loader: RTL

Hardware program loader that replaces bench-side program preloading. It accepts a byte stream over a valid/ready handshake and packs it into words in configurable byte order. It writes the words into instruction memory through a word write port, holds the CPU in reset during the load, then releases reset and raises the CPU enable. It sits between the host/UART byte source and the `control` block's instruction memory.

---
 rtl/boot_loader_pkg.sv | 22 ++
 rtl/word_packer.sv | 57 +++++
 rtl/boot_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and helpers for the program loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StHold,
    StDone,
    StErr
  } bl_state_t;

  // Values taken on reset.
  localparam bl_state_t   StateRst = StIdle;
  localparam int unsigned CountRst = 0;

  // Bytes per memory word.
  function automatic int unsigned bpw(input int unsigned word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Collects bytes into a word in the configured byte order.
// full flags that the next push completes the word; the first byte of a word zeroes the other slots.
module word_packer
  import boot_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter bit          ENDIAN_LE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        data,
  output logic              full,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned BPW   = bpw(WORD_W);
  localparam int unsigned SlotW = $clog2(BPW);

  logic [SlotW-1:0]  slot_q, slot_d;
  logic [WORD_W-1:0] word_q, word_d;
  int unsigned       pos;

  assign full = (slot_q == SlotW'(BPW - 1));
  assign word = word_q;

  // Place the incoming byte in its slot and advance the slot index.
  always_comb begin
    slot_d = slot_q;
    word_d = word_q;
    if (ENDIAN_LE) pos = 32'(slot_q);
    else           pos = BPW - 1 - 32'(slot_q);
    if (clear) begin
      slot_d = '0;
      word_d = '0;
    end else if (push) begin
      for (int unsigned i = 0; i < BPW; i++) begin
        if (i == pos)             word_d[i*8 +: 8] = data;
        else if (slot_q == '0)    word_d[i*8 +: 8] = 8'h00;
      end
      slot_d = full ? '0 : slot_q + 1'b1;
    end
  end

  // Slot and word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
      word_q <= '0;
    end else begin
      slot_q <= slot_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Streams bytes into instruction memory, holds the CPU in reset meanwhile, then enables it.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_BYTES   = 4096,
  parameter bit          ENDIAN_LE   = 1'b1,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int unsigned BPW       = bpw(WORD_W);
  localparam int unsigned HoldW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_W:0] MemBytesC = (ADDR_W + 1)'(MEM_BYTES);

  bl_state_t         state_q, state_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              accept, pk_clear, pk_full;

  // Ready depends only on registered state, never on s_valid.
  assign s_ready = (state_q == StLoad) && (byte_count_q < MemBytesC);
  assign accept  = s_valid & s_ready;

  word_packer #(
    .WORD_W   (WORD_W),
    .ENDIAN_LE(ENDIAN_LE)
  ) u_packer (
    .clk  (clk),
    .rst  (rst),
    .clear(pk_clear),
    .push (accept),
    .data (s_data),
    .full (pk_full),
    .word (mem_wdata)
  );

  // Next-state, counters and write-port decisions.
  always_comb begin
    state_d      = state_q;
    byte_count_d = byte_count_q;
    word_idx_d   = word_idx_q;
    hold_d       = hold_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    pk_clear     = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d      = StLoad;
          pk_clear     = 1'b1;
          byte_count_d = '0;
          word_idx_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          byte_count_d = byte_count_q + 1'b1;
          if (pk_full || s_last) begin
            mem_we_d   = 1'b1;
            mem_addr_d = ADDR_W'(word_idx_q * BPW);
          end
          if (pk_full) word_idx_d = word_idx_q + 1'b1;
          if (s_last) begin
            if (pk_full) begin
              state_d = StHold;
              // The write cycle itself is the first of the hold cycles.
              hold_d  = HoldW'(HOLD_CYCLES);
            end else begin
              state_d = StFlush;
            end
          end
        end else if (s_valid && (byte_count_q == MemBytesC)) begin
          state_d = StErr;
        end
      end
      StFlush: begin
        state_d = StHold;
        hold_d  = HoldW'(HOLD_CYCLES - 1);
      end
      StHold: begin
        if (hold_q == '0) state_d = StDone;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StateRst;
      byte_count_q <= (ADDR_W + 1)'(CountRst);
      word_idx_q   <= '0;
      hold_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_count_q <= byte_count_d;
      word_idx_q   <= word_idx_d;
      hold_q       <= hold_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign byte_count = byte_count_q;
  assign cpu_rst    = (state_q != StDone);
  assign cpu_enable = (state_q == StDone);
  assign done       = (state_q == StDone);
  assign err        = (state_q == StErr);
  assign busy       = (state_q == StLoad) || (state_q == StFlush) || (state_q == StHold);

endmodule
